// File: rtl/ring_link_pkg.sv
// Shared definitions for the ring link supervisor: FSM state codes, frame
// field positions and the transmit frame layout.
package ring_link_pkg;

    // FSM state encoding
    localparam logic [2:0] ST_RST  = 3'd0;
    localparam logic [2:0] ST_CAL  = 3'd1;
    localparam logic [2:0] ST_SYNC = 3'd2;
    localparam logic [2:0] ST_UP   = 3'd3;
    localparam logic [2:0] ST_FAIL = 3'd4;

    localparam int unsigned FRAME_W         = 64;
    localparam int unsigned FRAME_VALID_BIT = 63;
    localparam int unsigned SRC_MSB         = 62;
    localparam int unsigned SRC_LSB         = 60;
    localparam int unsigned SRC_W           = 3;
    localparam int unsigned PAYLOAD_W       = 60;
    localparam int unsigned RETRY_W         = 4;
    localparam logic [FRAME_W-1:0] IDLE_WORD = 64'h0;

    // On-wire frame: valid marker, source id, payload
    typedef struct packed {
        logic                 valid;
        logic [SRC_W-1:0]     src;
        logic [PAYLOAD_W-1:0] payload;
    } frame_t;

    function automatic frame_t make_frame(input logic [SRC_W-1:0]     src,
                                          input logic [PAYLOAD_W-1:0] payload);
        frame_t f;
        f.valid   = 1'b1;
        f.src     = src;
        f.payload = payload;
        return f;
    endfunction

endpackage

// File: rtl/ring_link_ctrl_rr_arbiter.sv
// Round-robin arbiter. Grants the first requester after the last-served one,
// wrapping; the pointer moves to the granted index when advance is high.
// Ports:
//   CLK, Reset  - clock, synchronous active-high reset
//   req         - request vector
//   advance     - commit the current grant (move the pointer)
//   grant_c     - one-hot grant, combinational
module rr_arbiter #(
    parameter int unsigned N = 4,
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic         CLK,
    input  logic         Reset,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant_c
);

    logic [PW-1:0] ptr;
    logic [PW-1:0] sel;
    logic [PW-1:0] idx;
    logic          found;

    // Scan from ptr+1 upward (mod N); first requester wins
    always_comb begin
        grant_c = '0;
        sel     = ptr;
        idx     = '0;
        found   = 1'b0;
        for (int k = 1; k <= int'(N); k++) begin
            idx = PW'((int'(ptr) + k) % int'(N));
            if (!found && req[idx]) begin
                grant_c[idx] = 1'b1;
                sel          = idx;
                found        = 1'b1;
            end
        end
    end

    // Pointer starts at N-1 so requester 0 has first priority after reset
    always_ff @(posedge CLK) begin
        if (Reset) begin
            ptr <= PW'(N - 1);
        end else if (advance && found) begin
            ptr <= sel;
        end
    end

endmodule

// File: rtl/ring_link_ctrl.sv
// Ring link supervisor and transmit scheduler. Brings the link up
// (reset pulse, calibration, partner handshake, retry/fail), then
// round-robin multiplexes requesters onto the transmit word and decodes
// received frames.
// Ports:
//   CLK, Reset                 - clock, synchronous active-high reset
//   enable                     - link enable; low returns to RST
//   ring_reset, ring_lock_in   - control to the ring link instance
//   ring_lock_out              - local calibration locked
//   partner_ready              - partner calibrated and ready
//   link_up, link_fail         - status (UP / FAIL state)
//   retry_cnt                  - saturating timeout count
//   req_valid/req_data/req_ready - requester interface (ready is combinational)
//   ring_din                   - registered transmit word
//   ring_dout                  - received word
//   rx_valid/rx_src/rx_data    - decoded received frame
module ring_link_ctrl
    import ring_link_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned RST_CYCLES   = 16,
    parameter int unsigned CAL_TIMEOUT  = 1024,
    parameter int unsigned SYNC_TIMEOUT = 65535,
    parameter int unsigned MAX_RETRY    = 7
) (
    input  logic                           CLK,
    input  logic                           Reset,
    input  logic                           enable,
    output logic                           ring_reset,
    input  logic                           ring_lock_out,
    output logic                           ring_lock_in,
    input  logic                           partner_ready,
    output logic                           link_up,
    output logic                           link_fail,
    output logic [RETRY_W-1:0]             retry_cnt,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*PAYLOAD_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [FRAME_W-1:0]             ring_din,
    input  logic [FRAME_W-1:0]             ring_dout,
    output logic                           rx_valid,
    output logic [SRC_W-1:0]               rx_src,
    output logic [PAYLOAD_W-1:0]           rx_data
);

    localparam int unsigned T_MAX =
        (RST_CYCLES > CAL_TIMEOUT)
            ? ((RST_CYCLES > SYNC_TIMEOUT) ? RST_CYCLES : SYNC_TIMEOUT)
            : ((CAL_TIMEOUT > SYNC_TIMEOUT) ? CAL_TIMEOUT : SYNC_TIMEOUT);
    localparam int unsigned TW = $clog2(T_MAX + 1);

    logic [2:0]         state, state_nx;
    logic [TW-1:0]      timer, timer_nx;
    logic [RETRY_W-1:0] retry_nx;
    logic               timeout;
    logic               enable_q;
    logic               up_d1, up_d2;
    logic               tx_en;
    frame_t             tx_frame;

    // State, timer and status registers
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state        <= ST_RST;
            timer        <= '0;
            retry_cnt    <= '0;
            enable_q     <= 1'b0;
            ring_reset   <= 1'b1;
            ring_lock_in <= 1'b0;
            link_up      <= 1'b0;
            link_fail    <= 1'b0;
            up_d1        <= 1'b0;
            up_d2        <= 1'b0;
        end else begin
            state        <= state_nx;
            timer        <= timer_nx;
            retry_cnt    <= retry_nx;
            enable_q     <= enable;
            ring_reset   <= (state_nx == ST_RST) || (state_nx == ST_FAIL);
            ring_lock_in <= (state_nx == ST_UP);
            link_up      <= (state_nx == ST_UP);
            link_fail    <= (state_nx == ST_FAIL);
            up_d1        <= link_up;
            up_d2        <= up_d1;
        end
    end

    // Next-state, timer and retry logic
    always_comb begin
        state_nx = state;
        timer_nx = timer;
        retry_nx = retry_cnt;
        timeout  = 1'b0;
        case (state)
            ST_RST: begin
                // Timer saturates while enable is low, so CAL follows as soon as enable returns
                if (timer == TW'(RST_CYCLES - 1)) begin
                    if (enable) state_nx = ST_CAL;
                end else begin
                    timer_nx = timer + TW'(1);
                end
            end
            ST_CAL: begin
                if (ring_lock_out)                         state_nx = ST_SYNC;
                else if (timer == TW'(CAL_TIMEOUT - 1))    timeout  = 1'b1;
                else                                       timer_nx = timer + TW'(1);
            end
            ST_SYNC: begin
                if (!ring_lock_out)                        state_nx = ST_RST;
                else if (partner_ready)                    state_nx = ST_UP;
                else if (timer == TW'(SYNC_TIMEOUT - 1))   timeout  = 1'b1;
                else                                       timer_nx = timer + TW'(1);
            end
            ST_UP: begin
                if (!ring_lock_out)                        timeout  = 1'b1;
                else if (!partner_ready)                   state_nx = ST_SYNC;
            end
            ST_FAIL: begin
                // Only a low-then-high enable sequence restarts bring-up
                if (enable && !enable_q) begin
                    state_nx = ST_RST;
                    retry_nx = '0;
                end
            end
            default: state_nx = ST_RST;
        endcase

        // Retry count never exceeds MAX_RETRY, so this increment saturates there
        if (timeout) begin
            if (retry_cnt == RETRY_W'(MAX_RETRY)) begin
                state_nx = ST_FAIL;
            end else begin
                state_nx = ST_RST;
                retry_nx = retry_cnt + RETRY_W'(1);
            end
        end

        if (!enable && (state != ST_FAIL)) begin
            state_nx = ST_RST;
            retry_nx = retry_cnt;
        end

        if (state_nx != state) timer_nx = '0;
    end

    // Data is held off until link_up has been high for two cycles
    assign tx_en = link_up & up_d1 & up_d2;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .CLK     (CLK),
        .Reset   (Reset),
        .req     (req_valid & {NUM_REQ{tx_en}}),
        .advance (tx_en),
        .grant_c (req_ready)
    );

    // Frame of the granted requester
    always_comb begin
        tx_frame = frame_t'(IDLE_WORD);
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (req_ready[i]) begin
                tx_frame = make_frame(SRC_W'(i), req_data[i*PAYLOAD_W +: PAYLOAD_W]);
            end
        end
    end

    // Transmit and receive registers
    always_ff @(posedge CLK) begin
        if (Reset) begin
            ring_din <= IDLE_WORD;
            rx_valid <= 1'b0;
            rx_src   <= '0;
            rx_data  <= '0;
        end else begin
            ring_din <= (|req_ready) ? FRAME_W'(tx_frame) : IDLE_WORD;
            rx_valid <= link_up & ring_dout[FRAME_VALID_BIT];
            if (link_up && ring_dout[FRAME_VALID_BIT]) begin
                rx_src  <= ring_dout[SRC_MSB:SRC_LSB];
                rx_data <= ring_dout[PAYLOAD_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_ring_link_ctrl.sv
// Randomized bench for ring_link_ctrl: a behavioural model predicts each
// cycle, a scoreboard queues expectations and a monitor compares them.
module tb_ring_link_ctrl;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned RSTC  = 16;
    localparam int unsigned CALT  = 1024;
    localparam int unsigned SYNCT = 300;
    localparam int unsigned MAXR  = 7;

    logic                 CLK = 1'b0;
    logic                 Reset;
    logic                 enable;
    logic                 ring_reset;
    logic                 ring_lock_out;
    logic                 ring_lock_in;
    logic                 partner_ready;
    logic                 link_up;
    logic                 link_fail;
    logic [3:0]           retry_cnt;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*60-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic [63:0]          ring_din;
    logic [63:0]          ring_dout;
    logic                 rx_valid;
    logic [2:0]           rx_src;
    logic [59:0]          rx_data;

    always #5 CLK = ~CLK;

    ring_link_ctrl #(
        .NUM_REQ(NREQ), .RST_CYCLES(RSTC), .CAL_TIMEOUT(CALT),
        .SYNC_TIMEOUT(SYNCT), .MAX_RETRY(MAXR)
    ) dut (
        .CLK(CLK), .Reset(Reset), .enable(enable),
        .ring_reset(ring_reset), .ring_lock_out(ring_lock_out),
        .ring_lock_in(ring_lock_in), .partner_ready(partner_ready),
        .link_up(link_up), .link_fail(link_fail), .retry_cnt(retry_cnt),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .ring_din(ring_din), .ring_dout(ring_dout),
        .rx_valid(rx_valid), .rx_src(rx_src), .rx_data(rx_data)
    );

    int total = 0;
    int bad   = 0;

    typedef enum {M_RST, M_CAL, M_SYNC, M_UP, M_FAIL} mphase_t;
    typedef struct {
        logic       rr, li, lu, lf;
        logic [3:0] retry;
        logic       tx;
        logic       rxv;
        logic [2:0] rsrc;
        logic [59:0] rdat;
    } stat_t;

    stat_t        stat_q[$];
    logic [63:0]  tx_q[$];
    bit           mon_on = 1'b0;

    // Reference model state
    mphase_t      ph;
    int           tmr, retry, up_run, ptr;
    bit           saw_low;
    logic [2:0]   m_rsrc;
    logic [59:0]  m_rdat;

    // Stimulus applied by step()
    logic               s_rst, s_en, s_lo, s_pr;
    logic [NREQ-1:0]    s_v;
    logic [NREQ*60-1:0] s_d;
    logic [63:0]        s_dout;

    int rr_cnt;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // One clock of stimulus; predicts req_ready now and registered outputs after the edge
    task automatic step();
        int      g;
        bit      to;
        mphase_t nph;
        stat_t   s;
        logic [NREQ-1:0] exp_rdy;
        @(negedge CLK);
        Reset = s_rst; enable = s_en; ring_lock_out = s_lo; partner_ready = s_pr;
        req_valid = s_v; req_data = s_d; ring_dout = s_dout;
        #1;
        g = -1;
        if (up_run >= 3) begin
            for (int k = 1; k <= int'(NREQ); k++) begin
                int idx;
                idx = (ptr + k) % int'(NREQ);
                if (g < 0 && ((s_v >> idx) & 1) != 0) g = idx;
            end
        end
        exp_rdy = (g >= 0) ? (NREQ'(1) << g) : '0;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));

        s.tx = 1'b0;
        s.rxv = 1'b0;
        if (s_rst) begin
            ph = M_RST; tmr = 0; retry = 0; up_run = 0; ptr = NREQ - 1;
            saw_low = 1'b0; m_rsrc = '0; m_rdat = '0;
        end else begin
            if (g >= 0) begin
                tx_q.push_back({1'b1, 3'(g), 60'(s_d >> (g * 60))});
                ptr = g;
                s.tx = 1'b1;
            end
            if (ph == M_UP && s_dout[63]) begin
                s.rxv = 1'b1;
                m_rsrc = s_dout[62:60];
                m_rdat = s_dout[59:0];
            end
            nph = ph;
            to  = 1'b0;
            if (ph != M_FAIL && !s_en) nph = M_RST;
            else begin
                case (ph)
                    M_RST:  if (tmr >= int'(RSTC) - 1) nph = M_CAL;
                    M_CAL:  if (s_lo) nph = M_SYNC; else if (tmr >= int'(CALT) - 1) to = 1'b1;
                    M_SYNC: if (!s_lo) nph = M_RST; else if (s_pr) nph = M_UP;
                            else if (tmr >= int'(SYNCT) - 1) to = 1'b1;
                    M_UP:   if (!s_lo) to = 1'b1; else if (!s_pr) nph = M_SYNC;
                    M_FAIL: if (s_en && saw_low) begin nph = M_RST; retry = 0; end
                endcase
            end
            if (to) begin
                if (retry == int'(MAXR)) nph = M_FAIL;
                else begin retry++; nph = M_RST; end
            end
            saw_low = (nph == M_FAIL) && (saw_low || (ph == M_FAIL && !s_en));
            tmr     = (nph != ph) ? 0 : tmr + 1;
            up_run  = (nph == M_UP) ? ((up_run < 10) ? up_run + 1 : 10) : 0;
            ph      = nph;
        end
        s.rr    = (ph == M_RST) || (ph == M_FAIL);
        s.li    = (ph == M_UP);
        s.lu    = (ph == M_UP);
        s.lf    = (ph == M_FAIL);
        s.retry = 4'(retry);
        s.rsrc  = m_rsrc;
        s.rdat  = m_rdat;
        stat_q.push_back(s);
        mon_on = 1'b1;
    endtask

    // Monitor: compares registered outputs after each active edge
    stat_t ms;
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (mon_on) begin
                if (stat_q.size() == 0) begin
                    chk("status_underflow", 64'(1), 64'(0));
                end else begin
                    ms = stat_q.pop_front();
                    chk("ring_reset",   64'(ring_reset),   64'(ms.rr));
                    chk("ring_lock_in", 64'(ring_lock_in), 64'(ms.li));
                    chk("link_up",      64'(link_up),      64'(ms.lu));
                    chk("link_fail",    64'(link_fail),    64'(ms.lf));
                    chk("retry_cnt",    64'(retry_cnt),    64'(ms.retry));
                    chk("tx_present",   64'(ring_din != 64'h0), 64'(ms.tx));
                    chk("rx_valid",     64'(rx_valid),     64'(ms.rxv));
                    chk("rx_src",       64'(rx_src),       64'(ms.rsrc));
                    chk("rx_data",      64'(rx_data),      64'(ms.rdat));
                end
                if (ring_din != 64'h0) begin
                    if (tx_q.size() == 0) chk("ring_din_unexpected", ring_din, 64'h0);
                    else                  chk("ring_din", ring_din, tx_q.pop_front());
                end
            end
        end
    end

    task automatic rand_data();
        for (int i = 0; i < int'(NREQ); i++) s_d[i*60 +: 60] = 60'({$urandom(), $urandom()});
    endtask

    initial begin
        Reset = 1'b1; enable = 1'b0; ring_lock_out = 1'b0; partner_ready = 1'b0;
        req_valid = '0; req_data = '0; ring_dout = '0;
        s_rst = 1'b1; s_en = 1'b1; s_lo = 1'b0; s_pr = 1'b0;
        s_v = '0; s_d = '0; s_dout = '0;
        ph = M_RST; tmr = 0; retry = 0; up_run = 0; ptr = NREQ - 1;
        saw_low = 1'b0; m_rsrc = '0; m_rdat = '0;

        repeat (3) step();

        // Bring-up with all requesters waiting: no grant before link_up+2
        s_rst = 1'b0; s_pr = 1'b1; rr_cnt = 0;
        s_v = 4'hF;
        for (int i = 0; i < int'(NREQ); i++) s_d[i*60 +: 60] = 60'(32'hA0 + i);
        for (int c = 0; c < 80; c++) begin
            if (ph == M_CAL && tmr >= 20) s_lo = 1'b1;
            step();
            if (ring_reset) rr_cnt++;
        end
        chk("ring_reset_len", 64'(rr_cnt), 64'(RSTC));
        chk("up_link_up",     64'(link_up), 64'(1));
        chk("up_lock_in",     64'(ring_lock_in), 64'(1));
        chk("up_retry",       64'(retry_cnt), 64'(0));

        // Partner drops mid-burst, then returns
        repeat (6) step();
        s_pr = 1'b0;
        repeat (6) step();
        s_pr = 1'b1;
        repeat (12) step();

        // Receive path
        s_v = '0;
        s_dout = 64'hD000_0000_0000_0123;
        step();
        s_dout = 64'h0;
        step();
        chk("rx_src_dir",  64'(rx_src),  64'(5));
        chk("rx_data_dir", 64'(rx_data), 64'h123);
        step();

        // Random traffic while up
        for (int c = 0; c < 800; c++) begin
            s_v = NREQ'($urandom());
            rand_data();
            s_dout = {$urandom(), $urandom()};
            if ($urandom_range(0, 49) == 0) s_pr = ~s_pr;
            step();
        end
        s_pr = 1'b1;
        repeat (30) step();

        // Reset while up with requests pending
        s_v = 4'hF;
        s_rst = 1'b1;
        step();
        s_rst = 1'b0;
        s_dout = 64'hD000_0000_0000_0123;
        step();
        chk("rst_link_up",    64'(link_up),    64'(0));
        chk("rst_ring_reset", 64'(ring_reset), 64'(1));
        chk("rst_ring_din",   ring_din,        64'h0);
        chk("rst_req_ready",  64'(req_ready),  64'(0));
        step();
        s_dout = 64'h0;

        // Calibration never locks: eight timeouts then FAIL
        s_lo = 1'b0; s_pr = 1'b0; s_v = '0;
        for (int c = 0; c < 10000 && ph != M_FAIL; c++) step();
        if (ph != M_FAIL) chk("fail_not_reached", 64'(0), 64'(1));
        step();
        chk("fail_link_fail",  64'(link_fail),  64'(1));
        chk("fail_retry",      64'(retry_cnt),  64'(MAXR));
        chk("fail_ring_reset", 64'(ring_reset), 64'(1));
        repeat (10) step();
        s_en = 1'b0;
        repeat (3) step();
        s_en = 1'b1;
        repeat (3) step();
        chk("reen_retry", 64'(retry_cnt), 64'(0));
        chk("reen_fail",  64'(link_fail), 64'(0));

        // Lock but no partner: SYNC timeouts
        s_lo = 1'b1;
        repeat (700) step();

        // Fully random control and traffic
        s_pr = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 199) == 0) s_en = ~s_en;
            if (!s_en && $urandom_range(0, 7) == 0) s_en = 1'b1;
            if ($urandom_range(0, 59) == 0) s_lo = ~s_lo;
            if ($urandom_range(0, 29) == 0) s_pr = ~s_pr;
            s_rst = ($urandom_range(0, 999) == 0);
            s_v = NREQ'($urandom());
            rand_data();
            s_dout = {$urandom(), $urandom()};
            step();
        end

        @(posedge CLK);
        #2;
        chk("status_q_empty", 64'(stat_q.size()), 64'(0));
        chk("tx_q_empty",     64'(tx_q.size()),   64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ring_link_ctrl.md
Name: ring_link_ctrl

Overview:
Link supervisor and transmit scheduler for one 32-pin DDR chip-to-chip ring link. Sequences bring-up of the ring link: reset pulse, calibration wait with timeout, partner handshake, retry and fail handling. Once the link is up, round-robin arbitrates up to 8 on-chip requesters onto the 64-bit transmit word and decodes received frames. Sits between fabric clients and the ring link instance, in the same CLK domain.

Parameters:
NUM_REQ, 4, number of requesters (1..8)
RST_CYCLES, 16, cycles ring_reset is held high per attempt
CAL_TIMEOUT, 1024, max cycles in CAL waiting for ring_lock_out
SYNC_TIMEOUT, 65535, max cycles in SYNC waiting for partner_ready
MAX_RETRY, 7, timeouts tolerated before FAIL (retry_cnt width 4)

Ports:
CLK  in  1  clock
Reset  in  1  synchronous, active-high
enable  in  1  link enable; low forces RST state
ring_reset  out  1  reset to ring link
ring_lock_out  in  1  local calibration locked (from ring link)
ring_lock_in  out  1  permission for ring link to enter normal operation
partner_ready  in  1  sideband: partner calibrated and ready
link_up  out  1  state==UP
link_fail  out  1  state==FAIL
retry_cnt  out  4  timeouts since Reset, saturating
req_valid  in  NUM_REQ  requester has a word
req_data  in  NUM_REQ*60  payloads; requester i uses bits [60i+59:60i]
req_ready  out  NUM_REQ  one-hot grant, combinational
ring_din  out  64  transmit word to ring link (registered)
ring_dout  in  64  received word from ring link
rx_valid  out  1  received frame valid
rx_src  out  3  source id of received frame
rx_data  out  60  received payload

Behaviour:
- Frame format: {1'b1, src[2:0], payload[59:0]}; idle word = 64'h0. Bit 63 marks a valid frame.
- Reset values: state=RST, ring_reset=1, ring_lock_in=0, link_up=0, link_fail=0, retry_cnt=0, ring_din=0, rx_valid=0, rx_src=0, rx_data=0, RR pointer=NUM_REQ-1, timer=0.
- FSM:
  - RST: ring_reset=1. Timer counts to RST_CYCLES-1, then CAL if enable, timer cleared.
  - CAL: ring_reset=0. ring_lock_out=1 -> SYNC. Timer reaching CAL_TIMEOUT-1 -> timeout.
  - SYNC: ring_lock_in=0. partner_ready=1 -> UP. ring_lock_out=0 -> RST, no retry increment. Timer reaching SYNC_TIMEOUT-1 -> timeout.
  - UP: ring_lock_in=1, link_up=1. partner_ready=0 -> SYNC, ring_lock_in deasserts the same cycle. ring_lock_out=0 -> timeout path.
  - FAIL: ring_reset=1, link_fail=1. Left only by Reset, or by enable low then high, which clears retry_cnt and enters RST.
- Timeout path: retry_cnt saturating increment. If the pre-increment retry_cnt==MAX_RETRY -> FAIL, else -> RST.
- enable=0 in any state except FAIL -> RST next cycle. retry_cnt unchanged. Stays in RST while enable=0.
- Timer clears on every state change.
- TX gating:
  - tx_en = link_up delayed 2 cycles, so the ring link reaches normal operation before real data arrives.
  - tx_en clears the cycle link_up falls.
- Arbitration:
  - With tx_en=1, req_ready = one-hot of the first valid requester after the RR pointer, wrapping.
  - Transfer when req_valid[i]&req_ready[i]. Pointer <= i on transfer.
  - When tx_en=0, req_ready=0.
- TX output: ring_din <= frame of the granted requester; 64'h0 if no transfer. Latency 1 cycle. Forced to 0 whenever tx_en=0.
- RX: rx_valid <= link_up & ring_dout[63]; rx_src/rx_data <= ring_dout[62:60]/[59:0] when valid, otherwise held. Latency 1 cycle. No flow control; the sink must accept every cycle.
- Reset mid-operation: all outputs return to reset values next cycle, and any in-flight grant is dropped.

Decomposition:
- Package ring_link_pkg: state encoding (RST, CAL, SYNC, UP, FAIL), FRAME_VALID_BIT=63, SRC_MSB=62, SRC_LSB=60, PAYLOAD_W=60, IDLE_WORD=64'h0.
- Sub-module rr_arbiter (parameter N): req, advance enable, one-hot grant, pointer register. Reused in later multi-link blocks.

Test Plan:
- Reset, enable=1; ring_lock_out rises 20 cycles after ring_reset falls; partner_ready=1 -> ring_reset high 16 cycles, SYNC then UP, link_up=1, ring_lock_in=1, retry_cnt=0.
- ring_lock_out held 0 -> CAL times out after 1024 cycles. Repeats. Eighth timeout gives link_fail=1, retry_cnt=7, ring_reset=1. enable low then high -> RST, retry_cnt=0.
- Link up, all 4 req_valid=1, payload i = 60'hA0+i -> ring_din sequence 64'h8..0A0, 9..0A1, A..0A2, B..0A3, then repeat. req_ready one-hot each cycle. First frame appears 1 cycle after grant, no grant before link_up+2.
- Link up, partner_ready drops mid-burst -> state SYNC, ring_lock_in=0, req_ready=0 same cycle, ring_din=0 next cycle. partner_ready returns -> UP, grants resume 2 cycles later.
- ring_dout=64'hD000_0000_0000_0123 while up -> next cycle rx_valid=1, rx_src=5, rx_data=60'h123. ring_dout=0 gives rx_valid=0. Same word while not up gives rx_valid=0.
- Reset asserted in UP with requests pending -> next cycle link_up=0, ring_reset=1, ring_din=0, req_ready=0.
